// File: rtl/addsub_multicycle_pkg.sv
// Shared definitions for the multi-cycle adder/subtractor.
//   OP_ADD / OP_SUB : encodings of the op input.
//   state_t         : controller states.
package addsub_multicycle_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/addsub_multicycle_if.sv
// Request/result bundle for addsub_multicycle.
//   master : drives start, op, a, b; observes busy, done, result, flags.
//   slave  : the arithmetic block.
interface addsub_multicycle_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;
   logic             zero;

   modport master (
      output start, op, a, b,
      input  busy, done, result, carry_out, overflow, zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, carry_out, overflow, zero
   );
endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple adder.
//   x, y  : chunk operands
//   cin   : carry in
//   s     : chunk sum
//   cout  : carry out of the chunk MSB
//   c_msb : carry into the chunk MSB (used for signed overflow)
module addsub_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             c_msb
);

   always_comb begin
      {cout, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
      // The sum bit at the MSB is x ^ y ^ carry_in, so the incoming carry falls out.
      c_msb = s[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];
   end

endmodule

// File: rtl/addsub_multicycle.sv
// Multi-cycle signed add/subtract, CHUNK bits per clock.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of addsub_multicycle_if (start/op/a/b in,
//                busy/done/result/carry_out/overflow/zero out)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | processing one chunk per cycle, idx = 0 .. N-1
// DONE  | one-cycle result-valid pulse; start here is accepted
module addsub_multicycle
   import addsub_multicycle_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input logic               clk,
   input logic               reset,
   addsub_multicycle_if.slave bus
);

   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   generate
      if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
         $error("addsub_multicycle: WIDTH must be an integer multiple of CHUNK");
      end
   endgenerate

   state_t           state, state_nxt;
   logic             accept;
   logic             busy, done;
   logic [WIDTH-1:0] a_q, b_q;
   logic             carry_q;
   logic [IDX_W-1:0] idx;
   logic             last;
   logic [WIDTH-1:0] result_q, result_nxt;
   logic             carry_out_q, overflow_q, zero_q;
   logic [CHUNK-1:0] x, y, s;
   logic             cout, c_msb;

   assign last = (idx == IDX_W'(N - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      x = a_q[idx*CHUNK +: CHUNK];
      y = b_q[idx*CHUNK +: CHUNK];
      result_nxt = result_q;
      result_nxt[idx*CHUNK +: CHUNK] = s;
   end

   addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .x     (x),
      .y     (y),
      .cin   (carry_q),
      .s     (s),
      .cout  (cout),
      .c_msb (c_msb)
   );

   // Subtract is folded in at accept time: b is stored inverted and the
   // carry seeded with 1, so RUN only ever adds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         idx         <= '0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         zero_q      <= 1'b1;
      end else if (accept) begin
         a_q     <= bus.a;
         b_q     <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
         carry_q <= bus.op;
         idx     <= '0;
      end else if (state == RUN) begin
         result_q <= result_nxt;
         carry_q  <= cout;
         if (last) begin
            idx         <= '0;
            carry_out_q <= cout;
            overflow_q  <= cout ^ c_msb;
            zero_q      <= (result_nxt == '0);
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.result    = result_q;
   assign bus.carry_out = carry_out_q;
   assign bus.overflow  = overflow_q;
   assign bus.zero      = zero_q;

endmodule
